// File: rtl/alu_writeback.sv
// -----------------------------------------------------------------------------
// alu_writeback
//
// Commit stage placed directly after the ALU. It takes one completed ALU
// operation (128-bit result, 64-bit flags, flag mask and register-write
// controls) into a holding register. It then retires the operation into
// architectural state:
//   - The lo and/or hi 64-bit halves are written through a single
//     register-file write port. One write takes one cycle. A lo+hi pair takes
//     two cycles, and the hi half is written second.
//   - The masked flags are merged into the RFLAGS register owned by this
//     block. The merge happens at the end of the first commit cycle. Bit 1 of
//     RFLAGS always reads as 1.
//   - retire pulses for one cycle in the final commit cycle of each operation.
//
// Ports
//   clk            in   clock, all state updates on posedge
//   reset          in   synchronous active-high reset
//   in_valid       in   upstream holds a completed ALU operation
//   in_ready       out  operation is accepted this cycle
//   in_result      in   [63:0] lo half, [127:64] hi half
//   in_flags       in   ALU-computed flags
//   in_flags_mask  in   1 = RFLAGS bit is updated by this operation
//   in_wr_lo/hi    in   write lo / hi half to the register file
//   in_dst_lo/hi   in   destination registers for lo / hi half
//   rf_we          out  register-file write enable
//   rf_waddr       out  register-file write address
//   rf_wdata       out  register-file write data
//   rflags         out  architectural RFLAGS
//   retire         out  one-cycle pulse in the final commit cycle
// -----------------------------------------------------------------------------
module alu_writeback #(
  parameter int          NREGS      = 16,
  parameter logic [63:0] RFLAGS_RST = 64'h2,
  localparam int         AW         = $clog2(NREGS)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [127:0]  in_result,
  input  logic [63:0]   in_flags,
  input  logic [63:0]   in_flags_mask,
  input  logic          in_wr_lo,
  input  logic          in_wr_hi,
  input  logic [AW-1:0] in_dst_lo,
  input  logic [AW-1:0] in_dst_hi,
  output logic          rf_we,
  output logic [AW-1:0] rf_waddr,
  output logic [63:0]   rf_wdata,
  output logic [63:0]   rflags,
  output logic          retire
);

  // RFLAGS bit 1 is architecturally reserved and always reads as 1.
  localparam logic [63:0] RFLAGS_FIXED1 = 64'h2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    C1   = 2'd1,
    C2   = 2'd2
  } state_t;

  typedef struct packed {
    logic [127:0]  result;
    logic [63:0]   flags;
    logic [63:0]   mask;
    logic          wr_lo;
    logic          wr_hi;
    logic [AW-1:0] dst_lo;
    logic [AW-1:0] dst_hi;
  } op_t;

  state_t state, state_nxt;
  op_t    held;
  op_t    incoming;
  logic   accept;
  logic   two_writes;

  assign incoming = '{
    result: in_result,
    flags:  in_flags,
    mask:   in_flags_mask,
    wr_lo:  in_wr_lo,
    wr_hi:  in_wr_hi,
    dst_lo: in_dst_lo,
    dst_hi: in_dst_hi
  };

  assign two_writes = held.wr_lo && held.wr_hi;
  assign accept     = in_valid && in_ready;

  // Outputs and next state are decoded from state and the holding register.
  // While reset is high, in_ready, rf_we and retire are all held low. This
  // means a reset that arrives mid-operation commits nothing.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // through the case leaves a signal unassigned and no latch is inferred.
    state_nxt = IDLE;
    in_ready  = 1'b0;
    rf_we     = 1'b0;
    rf_waddr  = '0;
    rf_wdata  = '0;
    retire    = 1'b0;

    if (!reset) begin
      unique case (state)
        IDLE: begin
          in_ready = 1'b1;
        end
        C1: begin
          if (held.wr_lo) begin
            rf_we    = 1'b1;
            rf_waddr = held.dst_lo;
            rf_wdata = held.result[63:0];
          end else if (held.wr_hi) begin
            rf_we    = 1'b1;
            rf_waddr = held.dst_hi;
            rf_wdata = held.result[127:64];
          end
          // A pending hi write keeps the holding register busy for one more cycle.
          in_ready = !two_writes;
          retire   = !two_writes;
        end
        C2: begin
          rf_we    = 1'b1;
          rf_waddr = held.dst_hi;
          rf_wdata = held.result[127:64];
          retire   = 1'b1;
          in_ready = 1'b1;
        end
        default: begin
          in_ready = 1'b0;
        end
      endcase

      if (state == C1 && two_writes) begin
        state_nxt = C2;
      end else if (accept) begin
        state_nxt = C1;
      end else begin
        state_nxt = IDLE;
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments only. This way every
    // flop samples its pre-edge value, whatever order the blocks run in.
    if (reset) begin
      // NOTE: the holding register is cleared on reset even though it is only
      // read in C1/C2. Doing so keeps the reset state fully deterministic at
      // the cost of a few reset flops.
      state  <= IDLE;
      held   <= '0;
      rflags <= RFLAGS_RST | RFLAGS_FIXED1;
    end else begin
      state <= state_nxt;
      if (accept) begin
        held <= incoming;
      end
      if (state == C1) begin
        rflags <= (rflags & ~held.mask) | (held.flags & held.mask) | RFLAGS_FIXED1;
      end
    end
  end

endmodule

// File: tb/tb_alu_writeback.sv
// -----------------------------------------------------------------------------
// tb_alu_writeback
//
// Directed bench for alu_writeback.
//
// The reference model treats each accepted operation as a short list of commit
// beats. An operation with one or no writes gives one beat. A lo+hi operation
// gives two beats. Beats are consumed one per clock. The block can take a new
// operation whenever at most one beat, the last beat of the current operation,
// is outstanding.
//
// A compare process checks in_ready, rf_*, retire and rflags against the model
// on every falling edge. The stimulus sequence also checks hand-computed
// literal values: register writes captured in a log, retire counts, and rflags.
// -----------------------------------------------------------------------------
module tb_alu_writeback;

  logic          clk;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [127:0]  in_result;
  logic [63:0]   in_flags;
  logic [63:0]   in_flags_mask;
  logic          in_wr_lo;
  logic          in_wr_hi;
  logic [3:0]    in_dst_lo;
  logic [3:0]    in_dst_hi;
  logic          rf_we;
  logic [3:0]    rf_waddr;
  logic [63:0]   rf_wdata;
  logic [63:0]   rflags;
  logic          retire;

  alu_writeback #(.NREGS(16), .RFLAGS_RST(64'h2)) dut (
    .clk           (clk),
    .reset         (reset),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_result     (in_result),
    .in_flags      (in_flags),
    .in_flags_mask (in_flags_mask),
    .in_wr_lo      (in_wr_lo),
    .in_wr_hi      (in_wr_hi),
    .in_dst_lo     (in_dst_lo),
    .in_dst_hi     (in_dst_hi),
    .rf_we         (rf_we),
    .rf_waddr      (rf_waddr),
    .rf_wdata      (rf_wdata),
    .rflags        (rflags),
    .retire        (retire)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int errors  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%h, expected 0x%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------- model
  typedef struct {
    logic        we;
    logic [3:0]  addr;
    logic [63:0] data;
    logic        ret;
    logic        upd;
    logic [63:0] flags;
    logic [63:0] mask;
  } beat_t;

  beat_t       q[$];
  logic [63:0] m_rflags = 64'h2;

  function automatic beat_t mk_beat(input logic we, input logic [3:0] addr,
                                    input logic [63:0] data, input logic ret,
                                    input logic upd, input logic [63:0] flags,
                                    input logic [63:0] mask);
    beat_t b;
    b.we = we; b.addr = addr; b.data = data; b.ret = ret;
    b.upd = upd; b.flags = flags; b.mask = mask;
    return b;
  endfunction

  initial begin
    forever begin
      logic  ready_now;
      logic  acc;
      beat_t b;
      @(posedge clk);
      ready_now = !reset && (q.size() <= 1);
      acc       = in_valid && ready_now;
      if (reset) begin
        q.delete();
        m_rflags = 64'h2;
      end else begin
        if (q.size() > 0) begin
          b = q.pop_front();
          if (b.upd) m_rflags = (m_rflags & ~b.mask) | (b.flags & b.mask) | 64'h2;
        end
        if (acc) begin
          if (in_wr_lo && in_wr_hi) begin
            q.push_back(mk_beat(1'b1, in_dst_lo, in_result[63:0], 1'b0, 1'b1, in_flags, in_flags_mask));
            q.push_back(mk_beat(1'b1, in_dst_hi, in_result[127:64], 1'b1, 1'b0, 64'h0, 64'h0));
          end else if (in_wr_lo) begin
            q.push_back(mk_beat(1'b1, in_dst_lo, in_result[63:0], 1'b1, 1'b1, in_flags, in_flags_mask));
          end else if (in_wr_hi) begin
            q.push_back(mk_beat(1'b1, in_dst_hi, in_result[127:64], 1'b1, 1'b1, in_flags, in_flags_mask));
          end else begin
            q.push_back(mk_beat(1'b0, 4'h0, 64'h0, 1'b1, 1'b1, in_flags, in_flags_mask));
          end
        end
      end
    end
  end

  // ------------------------------------------------------ compare + write log
  typedef struct {
    logic [3:0]  a;
    logic [63:0] d;
    int          cyc;
  } wr_t;

  wr_t wlog[$];
  int  retire_cnt = 0;
  int  cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    @(posedge clk);
    forever begin
      logic exp_we, exp_ret;
      @(negedge clk);
      exp_we  = !reset && q.size() > 0 && q[0].we;
      exp_ret = !reset && q.size() > 0 && q[0].ret;
      check("in_ready", {63'h0, in_ready}, {63'h0, !reset && (q.size() <= 1)});
      check("rf_we",    {63'h0, rf_we},    {63'h0, exp_we});
      check("retire",   {63'h0, retire},   {63'h0, exp_ret});
      check("rflags",   rflags,            m_rflags);
      if (exp_we && q.size() > 0) begin
        check("rf_waddr", {60'h0, rf_waddr}, {60'h0, q[0].addr});
        check("rf_wdata", rf_wdata,          q[0].data);
      end
      if (rf_we === 1'b1) wlog.push_back('{a: rf_waddr, d: rf_wdata, cyc: cyc});
      if (retire === 1'b1) retire_cnt++;
    end
  end

  // --------------------------------------------------------------- stimulus
  task automatic send(input logic [63:0] lo, input logic [63:0] hi,
                      input logic [63:0] flags, input logic [63:0] mask,
                      input logic wl, input logic wh,
                      input logic [3:0] dl, input logic [3:0] dh);
    int n;
    in_result     = {hi, lo};
    in_flags      = flags;
    in_flags_mask = mask;
    in_wr_lo      = wl;
    in_wr_hi      = wh;
    in_dst_lo     = dl;
    in_dst_hi     = dh;
    in_valid      = 1'b1;
    n = 0;
    forever begin
      @(negedge clk);
      if (in_ready === 1'b1) break;
      n++;
      if (n > 20) begin
        vectors++;
        errors++;
        $display("FAIL handshake_timeout: in_ready stuck at %b after %0d cycles", in_ready, n);
        break;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    wlog.delete();
    retire_cnt = 0;
  endtask

  task automatic check_wr(input int idx, input logic [3:0] a, input logic [63:0] d);
    if (idx < wlog.size()) begin
      check($sformatf("wlog[%0d].addr", idx), {60'h0, wlog[idx].a}, {60'h0, a});
      check($sformatf("wlog[%0d].data", idx), wlog[idx].d, d);
    end else begin
      vectors++;
      errors++;
      $display("FAIL wlog[%0d]: got no write, expected (%0d, 0x%h)", idx, a, d);
    end
  endtask

  task automatic check_consecutive(input int first, input int count);
    for (int i = first + 1; i < first + count; i++) begin
      if (i < wlog.size()) check($sformatf("wlog[%0d].cycle_gap", i), 64'(wlog[i].cyc - wlog[i-1].cyc), 64'd1);
    end
  endtask

  initial begin
    reset = 1'b1;
    in_valid = 1'b0;
    in_result = '0; in_flags = '0; in_flags_mask = '0;
    in_wr_lo = 1'b0; in_wr_hi = 1'b0; in_dst_lo = '0; in_dst_hi = '0;

    // Reset held for two cycles.
    @(posedge clk);
    @(negedge clk);
    check("reset.in_ready", {63'h0, in_ready}, 64'h0);
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("post_reset.rflags",   rflags,              64'h2);
    check("post_reset.rf_we",    {63'h0, rf_we},      64'h0);
    check("post_reset.retire",   {63'h0, retire},     64'h0);
    check("post_reset.in_ready", {63'h0, in_ready},   64'h1);
    @(posedge clk);
    #1;

    // Single write.
    clear_log();
    send(64'hDEAD_BEEF, 64'h0, 64'h41, 64'h8D5, 1'b1, 1'b0, 4'd3, 4'd0);
    idle(3);
    check("single.nwrites", 64'(wlog.size()), 64'd1);
    check_wr(0, 4'd3, 64'hDEAD_BEEF);
    check("single.retires", 64'(retire_cnt), 64'd1);
    check("single.rflags",  rflags, 64'h43);

    // Double write (RDX:RAX) followed immediately by a single write.
    clear_log();
    send(64'h1111, 64'h2222, 64'h0, 64'h0, 1'b1, 1'b1, 4'd0, 4'd2);
    send(64'h3333, 64'h0,    64'h0, 64'h0, 1'b1, 1'b0, 4'd5, 4'd0);
    idle(3);
    check("double.nwrites", 64'(wlog.size()), 64'd3);
    check_wr(0, 4'd0, 64'h1111);
    check_wr(1, 4'd2, 64'h2222);
    check_wr(2, 4'd5, 64'h3333);
    check_consecutive(0, 3);
    check("double.retires", 64'(retire_cnt), 64'd2);

    // Four back-to-back single writes with in_valid held high.
    clear_log();
    for (int i = 0; i < 4; i++)
      send(64'hA000 + 64'(i), 64'h0, 64'h0, 64'h0, 1'b1, 1'b0, 4'(4 + i), 4'd0);
    idle(3);
    check("b2b.nwrites", 64'(wlog.size()), 64'd4);
    for (int i = 0; i < 4; i++) check_wr(i, 4'(4 + i), 64'hA000 + 64'(i));
    check_consecutive(0, 4);
    check("b2b.retires", 64'(retire_cnt), 64'd4);

    // Hi-only write, then lo and hi to the same register (hi lands last).
    clear_log();
    send(64'h0, 64'h8888, 64'h0, 64'h0, 1'b0, 1'b1, 4'd0, 4'd8);
    send(64'hAAAA, 64'hBBBB, 64'h0, 64'h0, 1'b1, 1'b1, 4'd9, 4'd9);
    idle(3);
    check("samedst.nwrites", 64'(wlog.size()), 64'd3);
    check_wr(0, 4'd8, 64'h8888);
    check_wr(1, 4'd9, 64'hAAAA);
    check_wr(2, 4'd9, 64'hBBBB);

    // Flag merge using operations that do no register writes.
    clear_log();
    send(64'h0, 64'h0, 64'h8D7, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 4'd0, 4'd0);
    idle(2);
    check("flags.set",      rflags, 64'h8D7);
    check("nowrite.writes", 64'(wlog.size()), 64'd0);
    check("nowrite.retire", 64'(retire_cnt), 64'd1);
    send(64'h0, 64'h0, 64'h0, 64'h001, 1'b0, 1'b0, 4'd0, 4'd0);
    idle(2);
    check("flags.clr_bit0", rflags, 64'h8D6);
    send(64'h0, 64'h0, 64'h0, 64'h002, 1'b0, 1'b0, 4'd0, 4'd0);
    idle(2);
    check("flags.bit1_fixed", rflags, 64'h8D6);

    // Reset arriving during C1 of a double write.
    clear_log();
    send(64'h5555, 64'h6666, 64'hFFF, 64'hFFF, 1'b1, 1'b1, 4'd1, 4'd2);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    idle(3);
    check("midreset.writes",  64'(wlog.size()), 64'd0);
    check("midreset.retires", 64'(retire_cnt), 64'd0);
    check("midreset.rflags",  rflags, 64'h2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/alu_writeback.md
# alu_writeback

Commit stage that consumes the ALU's 128-bit result and 64-bit flags output and retires them into architectural state. It writes the low and/or high 64-bit halves to the integer register file through a single write port and merges flags into the architectural RFLAGS register it owns. It sits directly after the ALU. A valid/ready handshake toward the issue side lets single-write operations retire at one per cycle; double-write operations (e.g. wide MUL/DIV producing RDX:RAX) take two cycles.

## Interface
- NREGS, 16: number of architectural integer registers; address width is log2(NREGS).
- RFLAGS_RST, 64'h2: RFLAGS reset value; bit 1 is always read as 1.
- clk  in  1  single clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset, sampled on posedge clk.
- in_valid  in  1  upstream holds a completed ALU operation.
- in_ready  out  1  block accepts the operation this cycle.
- in_result  in  128  ALU result; [63:0] lo half, [127:64] hi half.
- in_flags  in  64  ALU-computed flags.
- in_flags_mask  in  64  1 = this bit of RFLAGS is updated by the operation.
- in_wr_lo / in_wr_hi  in  1 each  write the lo / hi half to the register file.
- in_dst_lo / in_dst_hi  in  log2(NREGS) each  destination registers.
- rf_we  out  1  register-file write enable.
- rf_waddr  out  log2(NREGS)  write address.
- rf_wdata  out  64  write data.
- rflags  out  64  architectural RFLAGS.
- retire  out  1  one-cycle pulse in the final commit cycle of each operation.

## Operation
- Acceptance: transfer occurs on a posedge with in_valid && in_ready. All in_* fields are captured into a single holding register.
- States:
  - IDLE: nothing held.
  - C1: first commit cycle.
  - C2: second commit cycle, entered only when both in_wr_lo and in_wr_hi are set.
- C1 behaviour:
  - If wr_lo: rf_we=1, rf_waddr=dst_lo, rf_wdata=result[63:0].
  - Else if wr_hi: write hi half to dst_hi.
  - Else: rf_we=0.
  - RFLAGS update takes effect at the end of C1: rflags <= (rflags & ~mask) | (flags & mask); bit 1 is then forced to 1.
- C2 behaviour: rf_we=1, rf_waddr=dst_hi, rf_wdata=result[127:64]. No flag update.
- retire is asserted in C1 when no C2 follows, otherwise in C2.
- in_ready = IDLE || (C1 && no C2 pending) || C2. A new operation can be captured in the same edge that ends the current one, giving back-to-back retirement.
- Transitions:
  - From IDLE, C1 or C2 that is finishing: go to C1 on accept, else IDLE.
  - From C1 with a hi write pending: go to C2 (in_ready=0).
- Same destination for lo and hi: hi is written second, so the hi half is the final value.
- An operation with no register writes and mask=0 still occupies one C1 cycle and pulses retire.

## Timing
- Reset values: state IDLE, holding register cleared, rf_we=0, rf_waddr=0, rf_wdata=0, retire=0, rflags=RFLAGS_RST, in_ready=0 during the reset cycle and 1 after it.
- rf_* and retire are combinational from the holding register and state, so they are valid during C1 and C2.
- Accept at edge N: C1 occupies cycle N..N+1, and the first write commits at edge N+1. rflags shows the new value after edge N+1. The second write, if any, commits at edge N+2.
- Reset asserted mid-operation: the held operation is discarded, with no further writes and no retire. rflags returns to RFLAGS_RST at that edge.
- Upstream must hold in_* stable while in_valid && !in_ready. The block does not sample in_* outside a transfer.

## Test plan
- Reset: hold reset for 2 cycles -> rflags=0x2, rf_we=0, retire=0, in_ready=1 on the first cycle after reset.
- Single write: result lo=0xDEAD_BEEF, dst_lo=3, flags=0x41, mask=0x8D5 -> one cycle with rf_we=1, waddr=3, wdata=0xDEADBEEF, retire=1; then rflags=0x43.
- Double write: lo=0x1111, hi=0x2222, dst_lo=0 (RAX), dst_hi=2 (RDX), back-to-back with another valid op -> writes (0,0x1111) then (2,0x2222); in_ready=0 in C1; retire only in C2; the next op commits the following cycle.
- Back-to-back single writes: 4 ops on consecutive cycles with in_valid held high -> 4 consecutive rf_we cycles, 4 retire pulses, in_ready stays 1.
- Flag merge: rflags=0x8D7, flags=0, mask=0x001 -> rflags=0x8D6. Then mask=0x002, flags=0 -> bit 1 stays 1.
- Reset during C1 of a double write -> no C2 write occurs, no retire, rflags=0x2.
